packet_sink: RTL and testbench
==============================

Name: packet_sink

Overview:
- Terminal consumer for a router local output port; the receiving end of the req/ack flit protocol that generators drive.
- Grants the sender, accepts head/body/tail flits, and checks packet structure and destination address.
- Reports completed and errored packets with saturating counters; feeds testbench scoreboards and on-chip traffic statistics.

Parameters:
- BODY_COUNT, 2, number of body flits expected per packet (at least 1).
- router_conf, '{default:9999}, ROUTER_CONFIG of the attached router; xaddr/yaddr are the expected head destination.
- TIMEOUT, 64, idle cycles tolerated inside a packet before the receive is aborted.
- CNT_W, 16, width of the packet and error counters.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_enable  in  1  sink may grant new packets
- i_rec_req  in  1  sender requests to transmit a packet
- o_rec_ack  out  1  grant; flits are accepted only while high
- i_flit  in  FLIT_t  incoming flit; valid = i_flit.flit[FLIT_SIZE-1]
- i_clear  in  1  synchronous clear of counters and error code
- o_pkt_done  out  1  one-cycle pulse: well-formed packet received
- o_pkt_err  out  1  one-cycle pulse: malformed packet detected
- o_err_code  out  3  last error code (sticky until i_clear)
- o_tail_tag  out  16  tail.reserved of the last good packet
- o_body_xor  out  16  XOR of body.data over the last good packet
- o_pkt_count  out  CNT_W  good packets, saturating
- o_err_count  out  CNT_W  errored packets, saturating

Behaviour:
- Reset: state IDLE; every output and internal counter is 0.
- States: IDLE, HEAD, BODY, TAIL, ERR, DRAIN.
- IDLE: if i_rec_req && i_enable, go to HEAD. o_rec_ack is registered: high from the first HEAD cycle, low again in IDLE.
- Flits without the valid bit are idles: ignored, and they increment the idle counter. Any accepted flit clears the idle counter.
- HEAD: a valid HEAD_FLIT with xaddr/yaddr equal to router_conf goes to BODY; body count and XOR accumulator are cleared.
  - Other valid flit type: code 1 (BAD_FIRST), go to ERR.
  - Address mismatch: code 2 (BAD_ADDR), go to ERR.
- BODY: each valid BODY_FLIT increments the count and XORs body.data into the accumulator. At count == BODY_COUNT, go to TAIL.
  - A HEAD or TAIL flit here: code 3 (BAD_BODY), go to ERR.
- TAIL: a valid TAIL_FLIT latches o_tail_tag and o_body_xor, pulses o_pkt_done, increments o_pkt_count, and returns to IDLE. Latency is 1 cycle: tail on edge N, pulse visible after edge N+1.
  - Any other valid flit: code 4 (BAD_TAIL), go to ERR.
- Timeout: the idle counter reaching TIMEOUT in HEAD, BODY or TAIL sets code 5 (TIMEOUT) and goes to ERR.
- ERR: one cycle. Pulses o_pkt_err, increments o_err_count. If the offending flit was a TAIL, or the error was a timeout, go to IDLE; otherwise go to DRAIN.
- DRAIN: ack stays high; valid flits are discarded until a TAIL (go to IDLE) or the idle counter reaches TIMEOUT (go to IDLE, no second error).
- i_rec_req falling mid-packet is ignored; only flits and the timeout advance the FSM.
- i_enable low blocks only new grants; a packet in progress completes.
- Counters saturate at all-ones.
- i_clear zeroes the counters and o_err_code. If i_clear coincides with a done/err event, clear wins and the event pulse still fires.
- Reset mid-packet aborts silently: no pulse, no count.

Optional Feature:
- Macro PACKET_SINK_LATENCY_EN.
- When defined: adds o_last_latency (16 bits), the cycle count from o_rec_ack rising to tail acceptance, plus o_max_latency (16 bits). Both update on o_pkt_done, saturate at all-ones, and are cleared by reset and i_clear.
- When undefined: neither port nor the counter exists, and all other behaviour is identical.

Decomposition:
- router_pkg: FLIT_t, FLIT_TYPE_t (HEAD_FLIT/BODY_FLIT/TAIL_FLIT/NONE_FLIT), FLIT_SIZE, ROUTER_CONFIG, and a new SINK_ERR_t enum for the codes above.
- Sub-module sat_counter (width parameter; inc/clear inputs; clear priority), instantiated for the packet, error and latency counters.

Test Plan:
- router_conf x=1/y=0, BODY_COUNT=2: head(1,0), bodies 0x0102 and 0x0300, tail reserved=0x00AB -> o_pkt_done once, o_body_xor=0x0202, o_tail_tag=0x00AB, o_pkt_count=1.
- Head addressed (2,0), then 2 bodies and a tail -> o_pkt_err, o_err_code=2, flits drained, ack drops after the tail, o_pkt_count=0, o_err_count=1.
- Head, 1 body, then tail -> o_err_code=3, FSM returns to IDLE with no DRAIN; next good packet -> o_pkt_count=1.
- Head, then 64 invalid cycles -> o_err_code=5, IDLE, o_rec_ack=0.
- reset asserted mid-body -> next cycle all outputs 0; a full packet afterwards completes normally.
- i_clear in the same cycle as a tail -> o_pkt_done pulses, o_pkt_count=0; with PACKET_SINK_LATENCY_EN, o_last_latency = ack-to-tail cycles (e.g. 4 for back-to-back flits).

Source files
------------

// File: rtl/packet_sink_pkg.sv
// packet_sink_pkg: shared types for the packet sink.
//   FLIT_t        : {valid, type[1:0], payload[15:0]}.
//   Head payload  : {xaddr[7:0], yaddr[7:0]}.
//   Body payload  : data. Tail payload: reserved tag.
//   ROUTER_CONFIG : attached-router coordinates. SINK_ERR_t: error codes.
package packet_sink_pkg;
  localparam int FLIT_SIZE = 19;
  localparam int PAYLOAD_W = 16;

  typedef enum logic [1:0] {
    HEAD_FLIT = 2'd0,
    BODY_FLIT = 2'd1,
    TAIL_FLIT = 2'd2,
    NONE_FLIT = 2'd3
  } FLIT_TYPE_t;

  typedef struct packed {
    logic [FLIT_SIZE-1:0] flit;
  } FLIT_t;

  typedef struct packed {
    int xaddr;
    int yaddr;
  } ROUTER_CONFIG;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    BAD_FIRST   = 3'd1,
    BAD_ADDR    = 3'd2,
    BAD_BODY    = 3'd3,
    BAD_TAIL    = 3'd4,
    ERR_TIMEOUT = 3'd5
  } SINK_ERR_t;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HEAD  = 3'd1,
    S_BODY  = 3'd2,
    S_TAIL  = 3'd3,
    S_ERR   = 3'd4,
    S_DRAIN = 3'd5
  } sink_state_t;

  function automatic logic flit_valid(input FLIT_t f);
    return f.flit[FLIT_SIZE-1];
  endfunction

  function automatic FLIT_TYPE_t flit_type(input FLIT_t f);
    return FLIT_TYPE_t'(f.flit[FLIT_SIZE-2 -: 2]);
  endfunction

  function automatic logic [PAYLOAD_W-1:0] flit_payload(input FLIT_t f);
    return f.flit[PAYLOAD_W-1:0];
  endfunction

  // Builds a valid flit of the given type.
  function automatic FLIT_t make_flit(input FLIT_TYPE_t t, input logic [PAYLOAD_W-1:0] p);
    FLIT_t f;
    f.flit = {1'b1, t, p};
    return f;
  endfunction

  // 16-bit increment that holds at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction
endpackage

// File: rtl/packet_sink_if.sv
// packet_sink_if: req/ack flit link between a generator and the sink.
//   rec_req : sender requests to transmit a packet (master -> slave)
//   flit    : incoming flit, MSB is the valid bit      (master -> slave)
//   rec_ack : grant, flits are accepted while high    (slave -> master)
interface packet_sink_if;
  logic                  rec_req;
  logic                  rec_ack;
  packet_sink_pkg::FLIT_t flit;

  modport master (output rec_req, output flit, input rec_ack);
  modport slave  (input rec_req, input flit, output rec_ack);
endinterface

// File: rtl/packet_sink_sat.sv
// sat_counter: synchronous up-counter that holds at all-ones.
//   clk, reset : clock, synchronous active-high reset
//   i_clear    : zero the count (wins over i_inc)
//   i_inc      : count one event
//   o_count    : current value (registered)
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_clear,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);
  logic [W-1:0] r_count;

  // Count register with clear priority and saturation.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= {W{1'b0}};
    end else if (i_clear) begin
      r_count <= {W{1'b0}};
    end else if (i_inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/packet_sink.sv
// packet_sink: terminal consumer of the req/ack flit protocol. Grants a
// sender, checks head/body/tail structure and head destination, and counts
// good and malformed packets.
//   clk, reset          : clock, synchronous active-high reset
//   i_enable            : allow new grants
//   rx (slave)          : rec_req / rec_ack / flit link
//   i_clear             : zero counters and error code
//   o_pkt_done/o_pkt_err: one-cycle event pulses
//   o_err_code          : last error code, sticky until i_clear
//   o_tail_tag/o_body_xor: tail tag and body XOR of last good packet
//   o_pkt_count/o_err_count: saturating event counters
// Optional macro PACKET_SINK_LATENCY_EN adds o_last_latency/o_max_latency.
module packet_sink
  import packet_sink_pkg::*;
#(
  parameter int           BODY_COUNT  = 2,
  parameter ROUTER_CONFIG router_conf = '{default: 9999},
  parameter int           TIMEOUT     = 64,
  parameter int           CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_enable,
  packet_sink_if.slave     rx,
  input  logic             i_clear,
  output logic             o_pkt_done,
  output logic             o_pkt_err,
  output logic [2:0]       o_err_code,
  output logic [15:0]      o_tail_tag,
  output logic [15:0]      o_body_xor,
  output logic [CNT_W-1:0] o_pkt_count,
  output logic [CNT_W-1:0] o_err_count
`ifdef PACKET_SINK_LATENCY_EN
  ,
  output logic [15:0]      o_last_latency,
  output logic [15:0]      o_max_latency
`endif
);
  localparam int BC_W   = $clog2(BODY_COUNT + 1);
  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  sink_state_t      r_state;
  logic             r_rec_ack, r_pkt_done, r_pkt_err, r_err_to_idle;
  logic [2:0]       r_err_code;
  logic [15:0]      r_tail_tag, r_body_xor, r_acc;
  logic [BC_W-1:0]  r_body_cnt;
  logic [IDLE_W-1:0] r_idle;

  logic             w_valid, w_grant, w_addr_ok, w_idle_to, w_is_tail;
  FLIT_TYPE_t       w_type;
  logic [15:0]      w_payload;
  logic [BC_W-1:0]  w_body_nxt;
  logic             w_err_evt, w_err_to_idle, w_done_evt;
  SINK_ERR_t        w_err_code;

  assign w_valid    = flit_valid(rx.flit);
  assign w_type     = flit_type(rx.flit);
  assign w_payload  = flit_payload(rx.flit);
  assign w_is_tail  = w_valid && (w_type == TAIL_FLIT);
  assign w_grant    = (r_state == S_IDLE) && rx.rec_req && i_enable;
  assign w_addr_ok  = ({24'd0, w_payload[15:8]} == router_conf.xaddr) &&
                      ({24'd0, w_payload[7:0]}  == router_conf.yaddr);
  // Fires on the idle cycle that brings the idle counter up to TIMEOUT.
  assign w_idle_to  = !w_valid && (r_idle == IDLE_W'(TIMEOUT - 1));
  assign w_body_nxt = r_body_cnt + BC_W'(1);

  // Error / completion decode for the current flit; feeds the FSM and counters.
  always_comb begin
    w_err_evt     = 1'b0;
    w_err_to_idle = 1'b0;
    w_err_code    = ERR_NONE;
    w_done_evt    = 1'b0;
    case (r_state)
      S_HEAD: begin
        if (w_valid && (w_type != HEAD_FLIT)) begin
          w_err_evt = 1'b1; w_err_code = BAD_FIRST; w_err_to_idle = w_is_tail;
        end else if (w_valid && !w_addr_ok) begin
          w_err_evt = 1'b1; w_err_code = BAD_ADDR;
        end else if (w_idle_to) begin
          w_err_evt = 1'b1; w_err_code = ERR_TIMEOUT; w_err_to_idle = 1'b1;
        end else begin
          w_err_evt = 1'b0;
        end
      end
      S_BODY: begin
        if (w_valid && ((w_type == HEAD_FLIT) || (w_type == TAIL_FLIT))) begin
          w_err_evt = 1'b1; w_err_code = BAD_BODY; w_err_to_idle = w_is_tail;
        end else if (w_idle_to) begin
          w_err_evt = 1'b1; w_err_code = ERR_TIMEOUT; w_err_to_idle = 1'b1;
        end else begin
          w_err_evt = 1'b0;
        end
      end
      S_TAIL: begin
        if (w_is_tail) begin
          w_done_evt = 1'b1;
        end else if (w_valid) begin
          w_err_evt = 1'b1; w_err_code = BAD_TAIL;
        end else if (w_idle_to) begin
          w_err_evt = 1'b1; w_err_code = ERR_TIMEOUT; w_err_to_idle = 1'b1;
        end else begin
          w_err_evt = 1'b0;
        end
      end
      default: begin
        w_err_evt = 1'b0;
      end
    endcase
  end

  // Receive FSM with registered ack, pulses, error code and packet results.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;   r_rec_ack <= 1'b0;   r_pkt_done <= 1'b0;
      r_pkt_err <= 1'b0;   r_err_to_idle <= 1'b0; r_err_code <= 3'd0;
      r_tail_tag <= 16'd0; r_body_xor <= 16'd0; r_acc <= 16'd0;
      r_body_cnt <= {BC_W{1'b0}}; r_idle <= {IDLE_W{1'b0}};
    end else begin
      r_pkt_done <= 1'b0;
      r_pkt_err  <= 1'b0;
      if (i_clear) begin
        r_err_code <= 3'd0;
      end else if (w_err_evt) begin
        r_err_code <= w_err_code;
      end else begin
        r_err_code <= r_err_code;
      end
      // Inside a packet: accepted flits restart the idle count.
      if (r_state == S_IDLE || w_valid) begin
        r_idle <= {IDLE_W{1'b0}};
      end else if (r_idle != IDLE_W'(TIMEOUT)) begin
        r_idle <= r_idle + IDLE_W'(1);
      end else begin
        r_idle <= r_idle;
      end
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_state   <= S_HEAD;
            r_rec_ack <= 1'b1;
          end else begin
            r_rec_ack <= 1'b0;
          end
        end
        S_HEAD, S_BODY, S_TAIL: begin
          if (w_err_evt) begin
            r_state       <= S_ERR;
            r_pkt_err     <= 1'b1;
            r_err_to_idle <= w_err_to_idle;
            r_idle        <= {IDLE_W{1'b0}};
          end else if (w_done_evt) begin
            r_state    <= S_IDLE;
            r_rec_ack  <= 1'b0;
            r_pkt_done <= 1'b1;
            r_tail_tag <= w_payload;
            r_body_xor <= r_acc;
          end else if (w_valid && (r_state == S_HEAD)) begin
            r_state    <= S_BODY;
            r_body_cnt <= {BC_W{1'b0}};
            r_acc      <= 16'd0;
          end else if (w_valid && (r_state == S_BODY) && (w_type == BODY_FLIT)) begin
            r_body_cnt <= w_body_nxt;
            r_acc      <= r_acc ^ w_payload;
            if (w_body_nxt == BC_W'(BODY_COUNT)) begin
              r_state <= S_TAIL;
            end else begin
              r_state <= S_BODY;
            end
          end else begin
            r_state <= r_state;
          end
        end
        S_ERR: begin
          // A tail arriving during the error cycle already ends the packet.
          if (r_err_to_idle || w_is_tail) begin
            r_state   <= S_IDLE;
            r_rec_ack <= 1'b0;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_is_tail || w_idle_to) begin
            r_state   <= S_IDLE;
            r_rec_ack <= 1'b0;
          end else begin
            r_state <= S_DRAIN;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_rec_ack <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_pkt_cnt (
    .clk(clk), .reset(reset), .i_clear(i_clear), .i_inc(w_done_evt), .o_count(o_pkt_count)
  );
  sat_counter #(.W(CNT_W)) u_err_cnt (
    .clk(clk), .reset(reset), .i_clear(i_clear), .i_inc(w_err_evt), .o_count(o_err_count)
  );

`ifdef PACKET_SINK_LATENCY_EN
  logic [15:0] w_lat_run, w_lat_now, r_last_lat, r_max_lat;
  logic        w_in_pkt;

  assign w_in_pkt  = (r_state == S_HEAD) || (r_state == S_BODY) || (r_state == S_TAIL);
  // Running count restarts when ack rises; the tail cycle itself is included.
  assign w_lat_now = sat_inc16(w_lat_run);

  sat_counter #(.W(16)) u_lat_cnt (
    .clk(clk), .reset(reset), .i_clear(w_grant), .i_inc(w_in_pkt), .o_count(w_lat_run)
  );

  // Latency results; a completing packet reloads them even under i_clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_lat <= 16'd0;
      r_max_lat  <= 16'd0;
    end else if (w_done_evt) begin
      r_last_lat <= w_lat_now;
      r_max_lat  <= (i_clear || (w_lat_now > r_max_lat)) ? w_lat_now : r_max_lat;
    end else if (i_clear) begin
      r_last_lat <= 16'd0;
      r_max_lat  <= 16'd0;
    end else begin
      r_last_lat <= r_last_lat;
      r_max_lat  <= r_max_lat;
    end
  end

  assign o_last_latency = r_last_lat;
  assign o_max_latency  = r_max_lat;
`endif

  assign rx.rec_ack = r_rec_ack;
  assign o_pkt_done = r_pkt_done;
  assign o_pkt_err  = r_pkt_err;
  assign o_err_code = r_err_code;
  assign o_tail_tag = r_tail_tag;
  assign o_body_xor = r_body_xor;
endmodule

// File: tb/tb_packet_sink.sv
// tb_packet_sink: directed self-checking bench for packet_sink
// (router x=1/y=0, BODY_COUNT=2, TIMEOUT=64, CNT_W=16).
module tb_packet_sink;
  import packet_sink_pkg::*;

  localparam ROUTER_CONFIG TB_CONF = '{xaddr: 1, yaddr: 0};

  logic        clk, reset, enable, clear;
  logic        pkt_done, pkt_err;
  logic [2:0]  err_code;
  logic [15:0] tail_tag, body_xor, pkt_count, err_count;
`ifdef PACKET_SINK_LATENCY_EN
  logic [15:0] last_lat, max_lat;
`endif
  int checks   = 0;
  int failures = 0;

  packet_sink_if vif();

  packet_sink #(.BODY_COUNT(2), .router_conf(TB_CONF), .TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .i_enable(enable), .rx(vif), .i_clear(clear),
    .o_pkt_done(pkt_done), .o_pkt_err(pkt_err), .o_err_code(err_code),
    .o_tail_tag(tail_tag), .o_body_xor(body_xor),
    .o_pkt_count(pkt_count), .o_err_count(err_count)
`ifdef PACKET_SINK_LATENCY_EN
    , .o_last_latency(last_lat), .o_max_latency(max_lat)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input FLIT_TYPE_t t, input logic [15:0] p);
    vif.flit = make_flit(t, p);
    tick();
  endtask

  task automatic send_idle();
    vif.flit = '{flit: 19'd0};
    tick();
  endtask

  // Raise req and wait (bounded) for the grant.
  task automatic grant(input string tag);
    vif.rec_req = 1'b1;
    for (int i = 0; i < 8 && vif.rec_ack !== 1'b1; i++) tick();
    vif.rec_req = 1'b0;
    chk(tag, {31'd0, vif.rec_ack}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; clear = 1'b0;
    vif.rec_req = 1'b0; vif.flit = '{flit: 19'd0};
    tick(); tick();
    reset = 1'b0;
    chk("rst_ack", {31'd0, vif.rec_ack}, 32'd0);
    chk("rst_done", {31'd0, pkt_done}, 32'd0);
    chk("rst_err", {31'd0, pkt_err}, 32'd0);
    chk("rst_code", {29'd0, err_code}, 32'd0);
    chk("rst_pkts", {16'd0, pkt_count}, 32'd0);
    chk("rst_errs", {16'd0, err_count}, 32'd0);

    // Good packet: bodies 0x0102 ^ 0x0300 = 0x0202.
    grant("a_grant");
    send(HEAD_FLIT, 16'h0100);
    send(BODY_FLIT, 16'h0102);
    send(BODY_FLIT, 16'h0300);
    chk("a_no_early_done", {31'd0, pkt_done}, 32'd0);
    send(TAIL_FLIT, 16'h00AB);
    chk("a_done", {31'd0, pkt_done}, 32'd1);
    chk("a_xor", {16'd0, body_xor}, 32'h0202);
    chk("a_tag", {16'd0, tail_tag}, 32'h00AB);
    chk("a_pkts", {16'd0, pkt_count}, 32'd1);
    chk("a_ack_low", {31'd0, vif.rec_ack}, 32'd0);
    send_idle();
    chk("a_done_pulse", {31'd0, pkt_done}, 32'd0);

    clear = 1'b1; tick(); clear = 1'b0;
    chk("clr_pkts", {16'd0, pkt_count}, 32'd0);

    // Wrong destination (2,0): error, then drain to tail.
    grant("b_grant");
    send(HEAD_FLIT, 16'h0200);
    chk("b_err", {31'd0, pkt_err}, 32'd1);
    chk("b_code", {29'd0, err_code}, 32'd2);
    chk("b_errs", {16'd0, err_count}, 32'd1);
    send(BODY_FLIT, 16'h1111);
    chk("b_err_pulse", {31'd0, pkt_err}, 32'd0);
    send(BODY_FLIT, 16'h2222);
    chk("b_drain_ack", {31'd0, vif.rec_ack}, 32'd1);
    send(TAIL_FLIT, 16'h3333);
    chk("b_ack_drop", {31'd0, vif.rec_ack}, 32'd0);
    chk("b_pkts", {16'd0, pkt_count}, 32'd0);
    chk("b_errs_once", {16'd0, err_count}, 32'd1);

    // Tail after one body: BAD_BODY, straight back to IDLE.
    grant("c_grant");
    send(HEAD_FLIT, 16'h0100);
    send(BODY_FLIT, 16'h0001);
    send(TAIL_FLIT, 16'h0002);
    chk("c_err", {31'd0, pkt_err}, 32'd1);
    chk("c_code", {29'd0, err_code}, 32'd3);
    send_idle();
    chk("c_idle_ack", {31'd0, vif.rec_ack}, 32'd0);
    grant("c2_grant");
    send(HEAD_FLIT, 16'h0100);
    send(BODY_FLIT, 16'hFFFF);
    send(BODY_FLIT, 16'h1234);
    send(TAIL_FLIT, 16'h5A5A);
    chk("c2_done", {31'd0, pkt_done}, 32'd1);
    chk("c2_xor", {16'd0, body_xor}, 32'hEDCB);
    chk("c2_tag", {16'd0, tail_tag}, 32'h5A5A);
    chk("c2_pkts", {16'd0, pkt_count}, 32'd1);

    // Body as first flit: BAD_FIRST; tail during error cycle ends it.
    grant("d_grant");
    send(BODY_FLIT, 16'h0100);
    chk("d_code", {29'd0, err_code}, 32'd1);
    chk("d_errs", {16'd0, err_count}, 32'd3);
    send(TAIL_FLIT, 16'h0000);
    chk("d_ack_low", {31'd0, vif.rec_ack}, 32'd0);

    // Third body where tail expected: BAD_TAIL, drain.
    grant("e_grant");
    send(HEAD_FLIT, 16'h0100);
    send(BODY_FLIT, 16'h0001);
    send(BODY_FLIT, 16'h0002);
    send(BODY_FLIT, 16'h0003);
    chk("e_code", {29'd0, err_code}, 32'd4);
    send_idle();
    chk("e_drain_ack", {31'd0, vif.rec_ack}, 32'd1);
    send(TAIL_FLIT, 16'h0004);
    chk("e_ack_low", {31'd0, vif.rec_ack}, 32'd0);
    chk("e_pkts", {16'd0, pkt_count}, 32'd1);

    // 64 idle cycles inside a packet: timeout on the 64th.
    grant("f_grant");
    send(HEAD_FLIT, 16'h0100);
    vif.flit = '{flit: 19'd0};
    for (int i = 0; i < 63; i++) tick();
    chk("f_no_early_to", {31'd0, pkt_err}, 32'd0);
    tick();
    chk("f_err", {31'd0, pkt_err}, 32'd1);
    chk("f_code", {29'd0, err_code}, 32'd5);
    chk("f_errs", {16'd0, err_count}, 32'd5);
    tick();
    chk("f_ack_low", {31'd0, vif.rec_ack}, 32'd0);

    // Enable low blocks grants.
    enable = 1'b0; vif.rec_req = 1'b1;
    tick(); tick(); tick();
    chk("g_no_grant", {31'd0, vif.rec_ack}, 32'd0);
    vif.rec_req = 1'b0; enable = 1'b1;
    tick();

    // Reset mid-body aborts silently, then a full packet works.
    grant("h_grant");
    send(HEAD_FLIT, 16'h0100);
    vif.flit = make_flit(BODY_FLIT, 16'h1111);
    reset = 1'b1; tick(); reset = 1'b0;
    vif.flit = '{flit: 19'd0};
    chk("h_ack", {31'd0, vif.rec_ack}, 32'd0);
    chk("h_err", {31'd0, pkt_err}, 32'd0);
    chk("h_code", {29'd0, err_code}, 32'd0);
    chk("h_errs", {16'd0, err_count}, 32'd0);
    chk("h_pkts", {16'd0, pkt_count}, 32'd0);
    chk("h_xor", {16'd0, body_xor}, 32'd0);
    chk("h_tag", {16'd0, tail_tag}, 32'd0);
    grant("h2_grant");
    send(HEAD_FLIT, 16'h0100);
    send(BODY_FLIT, 16'h00F0);
    send(BODY_FLIT, 16'h0F00);
    send(TAIL_FLIT, 16'h0001);
    chk("h2_done", {31'd0, pkt_done}, 32'd1);
    chk("h2_xor", {16'd0, body_xor}, 32'h0FF0);
    chk("h2_pkts", {16'd0, pkt_count}, 32'd1);

    // Clear coinciding with tail: pulse fires, count cleared.
    grant("i_grant");
    send(HEAD_FLIT, 16'h0100);
    send(BODY_FLIT, 16'h0C00);
    send(BODY_FLIT, 16'h000C);
    clear = 1'b1;
    send(TAIL_FLIT, 16'h0C0C);
    clear = 1'b0;
    chk("i_done", {31'd0, pkt_done}, 32'd1);
    chk("i_pkts", {16'd0, pkt_count}, 32'd0);
    chk("i_tag", {16'd0, tail_tag}, 32'h0C0C);
    chk("i_xor", {16'd0, body_xor}, 32'h0C0C);
`ifdef PACKET_SINK_LATENCY_EN
    chk("i_last_lat", {16'd0, last_lat}, 32'd4);
    chk("i_max_lat", {16'd0, max_lat}, 32'd4);
`endif
    send_idle();
    chk("i_done_pulse", {31'd0, pkt_done}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
